// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and instruction-fetch front end. It holds the 8-bit PC and
// updates it in IDLE from the PC-select command. It fetches one 16-bit
// instruction word per IL request over a simple req/ack memory handshake. A
// stalled fetch times out into HALT with fetch_error set.
//
// Ports
//   clk, reset           : clock; synchronous active-high reset
//   PS[1:0]              : PC select (0 hold, 1 inc, 2 relative, 3 absolute)
//   BC[1:0]              : branch condition (0 zero, 1 !zero, 2 negative, 3 always)
//   IL, EOE              : instruction-load request, end-of-execution request
//   zero, negative       : ALU flags for the current instruction
//   jr_target[7:0]       : absolute jump target
//   imem_addr/req/data/ack : instruction-memory handshake
//   instr[15:0]          : last accepted instruction word
//   opcode/Rd/Rs/Rt/imm8 : instruction fields decoded from instr
//   pc[7:0]              : current program counter
//   stall                : fetch in flight; control state must hold
//   halted, fetch_error  : HALT state indicator, fetch timeout indicator
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | PS applied every edge; IL starts a fetch, EOE halts
// FETCH_WAIT | request outstanding, waiting for imem_ack (max 15 cycles)
// HALT       | frozen until reset; entered on EOE or fetch timeout
// ---------------------------------------------------------------------------
module pc_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PS,
  input  logic [1:0]  BC,
  input  logic        IL,
  input  logic        EOE,
  input  logic        zero,
  input  logic        negative,
  input  logic [7:0]  jr_target,
  output logic [7:0]  imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_data,
  input  logic        imem_ack,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [3:0]  Rd,
  output logic [3:0]  Rs,
  output logic [3:0]  Rt,
  output logic [7:0]  imm8,
  output logic [7:0]  pc,
  output logic        stall,
  output logic        halted,
  output logic        fetch_error
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_FETCH_WAIT = 2'd1,
    S_HALT       = 2'd2
  } state_t;

  // The count reaches 14 on the 15th wait cycle. If no ack arrives on that
  // cycle's edge, the fetch is abandoned.
  localparam logic [3:0] WAIT_LAST = 4'd14;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  addr_q, addr_d;
  logic        req_q, req_d;
  logic [15:0] instr_q, instr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        cond_true;
  logic        wait_expired;
  logic [7:0]  pc_next_idle;

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= 8'h00;
      addr_q  <= 8'h00;
      req_q   <= 1'b0;
      instr_q <= 16'h0000;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  assign wait_expired = (cnt_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (EOE)     state_d = S_HALT;
        else if (IL) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (imem_ack)          state_d = S_IDLE;
        else if (wait_expired) state_d = S_HALT;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // PC update and fetch datapath
  // -------------------------------------------------------------------------
  always_comb begin
    cond_true = 1'b0;
    case (BC)
      2'd0:    cond_true = zero;
      2'd1:    cond_true = ~zero;
      2'd2:    cond_true = negative;
      default: cond_true = 1'b1;
    endcase
  end

  // In an 8-bit sum, sign-extending imm8 to 8 bits leaves it unchanged.
  // A plain 8-bit add therefore gives the mod-256 relative target.
  always_comb begin
    pc_next_idle = pc_q;
    case (PS)
      2'd0:    pc_next_idle = pc_q;
      2'd1:    pc_next_idle = pc_q + 8'd1;
      2'd2:    pc_next_idle = cond_true ? (pc_q + imm8) : pc_q;
      default: pc_next_idle = jr_target;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        // EOE wins over both IL and PS: the halt leaves the PC untouched.
        if (!EOE) begin
          pc_d = pc_next_idle;
          if (IL) begin
            // Fetch uses the PC before this edge's update.
            addr_d = pc_q;
            req_d  = 1'b1;
            cnt_d  = 4'd0;
          end
        end
      end
      S_FETCH_WAIT: begin
        if (imem_ack) begin
          instr_d = imem_data;
          req_d   = 1'b0;
        end else if (wait_expired) begin
          err_d = 1'b1;
          req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    stall  = (state_q == S_FETCH_WAIT);
    halted = (state_q == S_HALT);
  end

  assign pc          = pc_q;
  assign imem_addr   = addr_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign fetch_error = err_q;

  assign opcode = instr_q[15:12];
  assign Rd     = instr_q[11:8];
  assign Rs     = instr_q[7:4];
  assign Rt     = instr_q[3:0];
  assign imm8   = instr_q[7:0];

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: PS  in  2  PC select (0 hold, 1 increment, 2 relative jump, 3 absolute jump).
REQ-004 SHALL have ports: BC  in  2  branch condition (0 zero, 1 not-zero, 2 negative, 3 always).
REQ-005 SHALL have ports: IL  in  1  instruction-load request from control logic.
REQ-006 SHALL have ports: EOE  in  1  end-of-execution request.
REQ-007 SHALL have ports: zero, negative  in  1 each  ALU flags for the current instruction.
REQ-008 SHALL have ports: jr_target  in  8  register value for absolute jump.
REQ-009 SHALL have ports: imem_addr  out  8; imem_req  out  1; imem_data  in  16; imem_ack  in  1  (instruction-memory handshake).
REQ-010 SHALL have ports: instr  out  16; opcode  out  4 (instr[15:12]); Rd  out  4 (instr[11:8]); Rs  out  4 (instr[7:4]); Rt  out  4 (instr[3:0]); imm8  out  8 (instr[7:0]).
REQ-011 SHALL have ports: pc  out  8; stall  out  1 (fetch pending, control state register must hold); halted  out  1; fetch_error  out  1.

Function
REQ-012 SHALL implement states IDLE, FETCH_WAIT, HALT.
REQ-013 SHALL, in IDLE with IL=1 and EOE=0, latch imem_addr<=pc, set imem_req=1, enter FETCH_WAIT on the same edge.
REQ-014 SHALL, in IDLE, apply PS on every edge: 0 pc unchanged; 1 pc<=pc+1; 2 pc<=pc+sext(imm8) if condition true, else unchanged; 3 pc<=jr_target.
REQ-015 SHALL evaluate condition as BC=0: zero; BC=1: !zero; BC=2: negative; BC=3: 1.
REQ-016 SHALL compute all PC arithmetic modulo 256 (0xFF+1=0x00; 0x02+sext(0xFC)=0xFE).
REQ-017 SHALL, when IL=1 and PS=1 in the same IDLE cycle, fetch from the pre-increment pc and store pc+1.
REQ-018 SHALL, in FETCH_WAIT, hold imem_req=1 and imem_addr stable, ignore PS/IL/EOE, drive stall=1.
REQ-019 SHALL, on an edge in FETCH_WAIT with imem_ack=1, load instr<=imem_data, drop imem_req, return to IDLE; minimum IL-to-valid-instr latency 2 cycles.
REQ-020 SHALL ignore imem_ack outside FETCH_WAIT; instr changes only on an accepted ack.
REQ-021 SHALL count FETCH_WAIT cycles in a 4-bit counter cleared on FETCH_WAIT entry; if 15 cycles elapse without ack, set fetch_error=1, drop imem_req, enter HALT.
REQ-022 SHALL, in IDLE with EOE=1, enter HALT; EOE takes priority over IL; PS in that cycle not applied.
REQ-023 SHALL, in HALT, freeze pc and instr, hold imem_req=0, drive halted=1, stall=0; only reset exits.
REQ-024 SHALL drive stall=1 exactly while in FETCH_WAIT.
REQ-025 SHALL drive opcode/Rd/Rs/Rt/imm8 combinationally from instr.

Reset
REQ-026 SHALL on reset set state IDLE, pc=0x00, instr=0x0000, imem_addr=0x00, imem_req=0, halted=0, fetch_error=0, counter=0.
REQ-027 SHALL give reset priority over all inputs, including mid-fetch; an ack in the cycle after reset is ignored.
REQ-028 SHALL NOT require reset to be held more than one cycle.

Verification
REQ-029 SHALL cover: reset; IL=1,PS=1 at pc=0x00; ack next cycle with 0x8312 -> imem_addr=0x00, pc=0x01, instr=0x8312, opcode=8, Rd=3, stall high 1 cycle.
REQ-030 SHALL cover: pc=0x10, PS=2, BC=0, imm8=0xF0: zero=1 -> pc=0x00; zero=0 -> pc=0x10.
REQ-031 SHALL cover: pc=0xFF, PS=1 -> pc=0x00; PS=3, jr_target=0x42 -> pc=0x42.
REQ-032 SHALL cover: ack delayed 5 cycles -> imem_req high 5 cycles, PS=1 pulses during wait ignored, pc unchanged.
REQ-033 SHALL cover: no ack for 15 cycles -> fetch_error=1, halted=1, imem_req=0; later ack ignored.
REQ-034 SHALL cover: EOE=1 with IL=1 in IDLE -> HALT, no fetch; reset asserted mid-FETCH_WAIT -> req=0, pc=0x00 next cycle.
